// File: rtl/l2_lookup.sv
// L2 set-lookup sequencer: reads a set via localmem/l2_bufs, then
// reports hit way, first empty way and round-robin victim to the L2 FSM.
package l2_pkg;
    typedef logic [19:0] l2_tag_t;
    typedef logic [1:0]  state_t;
    localparam state_t ST_INVALID = 2'd0;
endpackage

module l2_lookup
    import l2_pkg::*;
#(
    parameter int WAYS        = 8,
    parameter int WORDS       = 4,
    parameter int LMEM_RD_LAT = 1,
    localparam int WW         = $clog2(WAYS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lookup_req_valid,
    output logic          lookup_req_ready,
    input  l2_tag_t       lookup_tag,
    output logic          lmem_rd_en,
    output logic          rd_set_into_bufs,
    input  l2_tag_t       tags_buf [WAYS],
    input  state_t        states_buf [WAYS][WORDS],
    output logic          lookup_resp_valid,
    input  logic          lookup_resp_ready,
    output logic          lookup_hit,
    output logic [WW-1:0] lookup_hit_way,
    output logic          lookup_multi_hit,
    output logic          lookup_empty_found,
    output logic [WW-1:0] lookup_empty_way,
    output logic [WW-1:0] lookup_evict_way
);

    localparam int CW        = $clog2(LMEM_RD_LAT + 1);
    localparam int WAIT_LAST = (LMEM_RD_LAT > 1) ? LMEM_RD_LAT - 2 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_CMP,
        S_RESP
    } fsm_t;

    fsm_t          state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    l2_tag_t       tag_q;
    logic          hit_q, multi_q, empty_q;
    logic [WW-1:0] hit_way_q, empty_way_q, evict_q;

    logic          hit_c, multi_c, empty_c, way_vld;
    logic [WW-1:0] hit_way_c, empty_way_c;

    logic req_hs, resp_hs;

    assign req_hs  = (state == S_IDLE) && lookup_req_valid;
    assign resp_hs = (state == S_RESP) && lookup_resp_ready;

    // Lowest index wins for both the hit and the empty way.
    always_comb begin
        hit_c       = 1'b0;
        multi_c     = 1'b0;
        empty_c     = 1'b0;
        hit_way_c   = '0;
        empty_way_c = '0;
        way_vld     = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            way_vld = 1'b0;
            for (int k = 0; k < WORDS; k++) begin
                if (states_buf[w][k] != ST_INVALID) way_vld = 1'b1;
            end
            if (way_vld && tags_buf[w] == tag_q) begin
                if (hit_c) begin
                    multi_c = 1'b1;
                end else begin
                    hit_c     = 1'b1;
                    hit_way_c = WW'(w);
                end
            end
            if (!way_vld && !empty_c) begin
                empty_c     = 1'b1;
                empty_way_c = WW'(w);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (lookup_req_valid) begin
                    cnt_nxt   = '0;
                    state_nxt = (LMEM_RD_LAT > 1) ? S_WAIT : S_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt == CW'(WAIT_LAST)) state_nxt = S_LOAD;
                else cnt_nxt = cnt + CW'(1);
            end
            S_LOAD:  state_nxt = S_CMP;
            S_CMP:   state_nxt = S_RESP;
            S_RESP:  if (lookup_resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            tag_q       <= '0;
            hit_q       <= 1'b0;
            multi_q     <= 1'b0;
            empty_q     <= 1'b0;
            hit_way_q   <= '0;
            empty_way_q <= '0;
            evict_q     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (req_hs) tag_q <= lookup_tag;
            if (state == S_CMP) begin
                hit_q       <= hit_c;
                multi_q     <= multi_c;
                empty_q     <= empty_c;
                hit_way_q   <= hit_way_c;
                empty_way_q <= empty_way_c;
            end
            // Victim only consumed when the set is full and missed.
            if (resp_hs && !hit_q && !empty_q) evict_q <= evict_q + WW'(1);
        end
    end

    assign lookup_req_ready   = (state == S_IDLE);
    assign lmem_rd_en         = req_hs;
    assign rd_set_into_bufs   = (state == S_LOAD);
    assign lookup_resp_valid  = (state == S_RESP);
    assign lookup_hit         = hit_q;
    assign lookup_hit_way     = hit_way_q;
    assign lookup_multi_hit   = multi_q;
    assign lookup_empty_found = empty_q;
    assign lookup_empty_way   = empty_way_q;
    assign lookup_evict_way   = evict_q;

endmodule

// File: tb/tb_l2_lookup.sv
// Testbench for l2_lookup: randomized set contents checked against
// a behavioural lookup model; also a LMEM_RD_LAT=3 instance for timing.
module tb_l2_lookup;
    import l2_pkg::*;

    localparam int WAYS  = 8;
    localparam int WORDS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    l2_tag_t tags_buf [WAYS];
    state_t  states_buf [WAYS][WORDS];
    l2_tag_t lookup_tag;

    logic req_valid, req_ready, rd_en, rd_set, resp_valid, resp_ready;
    logic hit, multi, empty;
    logic [2:0] hit_way, empty_way, evict_way;

    logic req_valid3, req_ready3, rd_en3, rd_set3, resp_valid3, resp_ready3;
    logic hit3, multi3, empty3;
    logic [2:0] hit_way3, empty_way3, evict_way3;

    l2_lookup #(.WAYS(WAYS), .WORDS(WORDS), .LMEM_RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .lookup_req_valid(req_valid), .lookup_req_ready(req_ready),
        .lookup_tag(lookup_tag), .lmem_rd_en(rd_en),
        .rd_set_into_bufs(rd_set), .tags_buf(tags_buf),
        .states_buf(states_buf), .lookup_resp_valid(resp_valid),
        .lookup_resp_ready(resp_ready), .lookup_hit(hit),
        .lookup_hit_way(hit_way), .lookup_multi_hit(multi),
        .lookup_empty_found(empty), .lookup_empty_way(empty_way),
        .lookup_evict_way(evict_way)
    );

    l2_lookup #(.WAYS(WAYS), .WORDS(WORDS), .LMEM_RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .lookup_req_valid(req_valid3), .lookup_req_ready(req_ready3),
        .lookup_tag(lookup_tag), .lmem_rd_en(rd_en3),
        .rd_set_into_bufs(rd_set3), .tags_buf(tags_buf),
        .states_buf(states_buf), .lookup_resp_valid(resp_valid3),
        .lookup_resp_ready(resp_ready3), .lookup_hit(hit3),
        .lookup_hit_way(hit_way3), .lookup_multi_hit(multi3),
        .lookup_empty_found(empty3), .lookup_empty_way(empty_way3),
        .lookup_evict_way(evict_way3)
    );

    int total = 0;
    int bad   = 0;
    int mptr  = 0;

    logic       e_hit, e_mh, e_ef;
    logic [2:0] e_hw, e_ew;
    logic [11:0] o_res;
    int o_lat, o_rd, o_ld;
    logic o_rdy1, o_vld1;

    function automatic logic [11:0] exp_res();
        return {e_hit, e_hw, e_mh, e_ef, e_ew, 3'(mptr)};
    endfunction

    function automatic logic [11:0] dut_res();
        return {hit, hit_way, multi, empty, empty_way, evict_way};
    endfunction

    // Reference: count matching valid ways, pick lowest by scanning downward.
    task automatic model(input l2_tag_t t);
        int n;
        logic v;
        n = 0; e_hw = '0; e_ef = 1'b0; e_ew = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            v = 1'b0;
            for (int k = 0; k < WORDS; k++) v = v | (states_buf[w][k] != 2'd0);
            if (v && tags_buf[w] == t) begin n++; e_hw = 3'(w); end
            if (!v) begin e_ef = 1'b1; e_ew = 3'(w); end
        end
        e_hit = (n > 0);
        e_mh  = (n > 1);
    endtask

    task automatic advance_ptr();
        if (!e_hit && !e_ef) mptr = (mptr + 1) % WAYS;
    endtask

    task automatic set_way(input int w, input l2_tag_t t, input state_t s);
        tags_buf[w] = t;
        for (int k = 0; k < WORDS; k++) states_buf[w][k] = s;
    endtask

    task automatic clear_bufs();
        for (int w = 0; w < WAYS; w++) set_way(w, 20'($urandom), 2'd0);
    endtask

    task automatic xact(input l2_tag_t t, input int hold);
        lookup_tag = t;
        req_valid  = 1'b1;
        #1;
        o_rd = int'(rd_en);
        o_ld = 0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        o_lat = 1;
        while (!resp_valid && o_lat < 20) begin
            o_rd += int'(rd_en);
            o_ld += int'(rd_set);
            @(posedge clk); #1;
            o_lat++;
        end
        o_res = dut_res();
        repeat (hold) begin @(posedge clk); #1; end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        o_rdy1 = req_ready;
        o_vld1 = resp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({req_ready, resp_valid, rd_en, rd_set, dut_res()} !== {4'b1000, 12'h0}) begin
            bad++;
            $display("FAIL reset got=%h exp=%h",
                     {req_ready, resp_valid, rd_en, rd_set, dut_res()}, {4'b1000, 12'h0});
        end
        total++;
        if ({req_ready3, resp_valid3, rd_en3, rd_set3, evict_way3} !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_lat3 got=%b exp=1000000",
                     {req_ready3, resp_valid3, rd_en3, rd_set3, evict_way3});
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_hit();
        clear_bufs();
        set_way(5, 20'h001A3, 2'd1);
        model(20'h001A3);
        xact(20'h001A3, 0);
        total++;
        if ({o_lat, o_rd, o_ld} !== {32'd3, 32'd1, 32'd1}) begin
            bad++;
            $display("FAIL hit_timing got lat=%0d rd=%0d ld=%0d exp 3/1/1", o_lat, o_rd, o_ld);
        end
        total++;
        if (o_res !== exp_res() || o_res[11:8] !== 4'hD) begin
            bad++;
            $display("FAIL hit_result got=%h exp=%h", o_res, exp_res());
        end
        total++;
        if ({o_rdy1, o_vld1} !== 2'b10) begin
            bad++;
            $display("FAIL hit_release got=%b exp=10", {o_rdy1, o_vld1});
        end
        advance_ptr();
    endtask

    task automatic test_empty();
        for (int w = 0; w < WAYS; w++) set_way(w, 20'h00200 + 20'(w), 2'd2);
        set_way(2, 20'h00ABC, 2'd0);
        model(20'h00ABC);
        xact(20'h00ABC, 2);
        total++;
        if (o_res !== exp_res() || o_res[11] !== 1'b0 || o_res[6:3] !== 4'b1010) begin
            bad++;
            $display("FAIL empty_result got=%h exp=%h", o_res, exp_res());
        end
        advance_ptr();
        total++;
        if (evict_way !== 3'(mptr)) begin
            bad++;
            $display("FAIL empty_ptr got=%0d exp=%0d", evict_way, mptr);
        end
    endtask

    task automatic test_full_wrap();
        for (int w = 0; w < WAYS; w++) set_way(w, 20'h00300 + 20'(w), 2'd1);
        model(20'h000FF);
        while (mptr != 7) begin
            xact(20'h000FF, 0);
            total++;
            if (o_res !== exp_res()) begin
                bad++;
                $display("FAIL wrap_pre got=%h exp=%h", o_res, exp_res());
            end
            advance_ptr();
        end
        xact(20'h000FF, 1);
        total++;
        if (o_res !== exp_res() || o_res[2:0] !== 3'd7) begin
            bad++;
            $display("FAIL wrap_7 got=%h exp=%h", o_res, exp_res());
        end
        advance_ptr();
        total++;
        if (evict_way !== 3'd0 || mptr != 0) begin
            bad++;
            $display("FAIL wrap_0 got=%0d exp=0", evict_way);
        end
        xact(20'h000FF, 0);
        advance_ptr();
    endtask

    task automatic test_backpressure();
        clear_bufs();
        set_way(6, 20'h00055, 2'd3);
        model(20'h00055);
        lookup_tag = 20'h00055;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 10; i++) begin
            req_valid  = 1'b1;
            lookup_tag = 20'($urandom);
            #1;
            total++;
            if ({resp_valid, req_ready, rd_en, dut_res()} !== {3'b100, exp_res()}) begin
                bad++;
                $display("FAIL bp_hold[%0d] got=%h exp=%h", i,
                         {resp_valid, req_ready, rd_en, dut_res()}, {3'b100, exp_res()});
            end
            @(posedge clk); #1;
        end
        lookup_tag = 20'h00055;
        resp_ready = 1'b1;
        #1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        total++;
        if ({req_ready, rd_en, resp_valid} !== 3'b110) begin
            bad++;
            $display("FAIL bp_accept_next got=%b exp=110", {req_ready, rd_en, resp_valid});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        o_lat = 1;
        while (!resp_valid && o_lat < 20) begin @(posedge clk); #1; o_lat++; end
        total++;
        if (o_lat != 3 || dut_res() !== exp_res()) begin
            bad++;
            $display("FAIL bp_second got lat=%0d res=%h exp lat=3 res=%h", o_lat, dut_res(), exp_res());
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < WAYS; w++) begin
                tags_buf[w] = 20'h00010 + 20'($urandom_range(0, 3));
                for (int k = 0; k < WORDS; k++)
                    states_buf[w][k] = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            end
            lookup_tag = 20'h00010 + 20'($urandom_range(0, 3));
            model(lookup_tag);
            xact(lookup_tag, $urandom_range(0, 3));
            total++;
            if (o_res !== exp_res() || o_lat != 3) begin
                bad++;
                $display("FAIL random[%0d] got=%h lat=%0d exp=%h lat=3", it, o_res, o_lat, exp_res());
            end
            advance_ptr();
        end
    endtask

    task automatic test_lat3();
        int cyc, rd_at, ld_at, rs_at, rdn, ldn;
        clear_bufs();
        set_way(3, 20'h002B7, 2'd1);
        set_way(1, 20'h002B7, 2'd0);
        model(20'h002B7);
        lookup_tag = 20'h002B7;
        req_valid3 = 1'b1;
        #1;
        rd_at = -1; ld_at = -1; rs_at = -1; rdn = 0; ldn = 0;
        for (cyc = 0; cyc < 30 && rs_at < 0; cyc++) begin
            if (rd_en3) begin rdn++; rd_at = cyc; end
            if (rd_set3) begin ldn++; ld_at = cyc; end
            if (resp_valid3) rs_at = cyc;
            else begin @(posedge clk); #1; req_valid3 = 1'b0; end
        end
        total++;
        if ({rd_at, ld_at, rs_at, rdn, ldn} !== {32'd0, 32'd3, 32'd5, 32'd1, 32'd1}) begin
            bad++;
            $display("FAIL lat3_timing got rd=%0d ld=%0d resp=%0d n=%0d/%0d exp 0/3/5 n=1/1",
                     rd_at, ld_at, rs_at, rdn, ldn);
        end
        total++;
        if ({hit3, hit_way3, multi3, empty3, empty_way3} !== {e_hit, e_hw, e_mh, e_ef, e_ew}) begin
            bad++;
            $display("FAIL lat3_result got=%h exp=%h", {hit3, hit_way3, multi3, empty3, empty_way3},
                     {e_hit, e_hw, e_mh, e_ef, e_ew});
        end
        resp_ready3 = 1'b1;
        @(posedge clk); #1;
        resp_ready3 = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int w = 0; w < WAYS; w++) set_way(w, 20'h00400 + 20'(w), 2'd1);
        lookup_tag = 20'h00099;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if ({req_ready, resp_valid, rd_en, rd_set, evict_way, hit} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_mid got=%b exp=10000000",
                     {req_ready, resp_valid, rd_en, rd_set, evict_way, hit});
        end
        @(posedge clk); #1;
        rst  = 1'b1;
        mptr = 0;
        @(posedge clk); #1;
        model(20'h00099);
        xact(20'h00099, 0);
        total++;
        if (o_res !== exp_res() || o_lat != 3) begin
            bad++;
            $display("FAIL post_reset got=%h lat=%0d exp=%h lat=3", o_res, o_lat, exp_res());
        end
        advance_ptr();
    endtask

    initial begin
        req_valid = 1'b0; resp_ready = 1'b0;
        req_valid3 = 1'b0; resp_ready3 = 1'b0;
        lookup_tag = '0;
        clear_bufs();
        test_reset();
        test_hit();
        test_empty();
        test_full_wrap();
        test_backpressure();
        test_random();
        test_lat3();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
